// File: rtl/counter_ctrl.sv
// Run controller for the two-digit 7-segment counter: button edges drive an IDLE/RUN/PAUSE/DONE
// sequence, a prescaler paces counting. Optional macro COUNTER_CTRL_DOWN_EN adds a 'dir' input for down-counting.
module counter_ctrl #(
    parameter int DIV       = 4,
    parameter int MAX_COUNT = 3,
    parameter bit WRAP      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
`ifdef COUNTER_CTRL_DOWN_EN
    input  logic        dir,
`endif
    output logic [6:0]  count,
    output logic [13:0] result,
    output logic        running,
    output logic        tick,
    output logic        done
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [6:0] MAXV = 7'(MAX_COUNT);

    generate
        if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max
            $error("counter_ctrl: MAX_COUNT must be within 1..99");
        end
        if (DIV < 2) begin : g_bad_div
            $error("counter_ctrl: DIV must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          start_q, stop_q, clear_q;
    logic          start_e, stop_e, clear_e;
    logic          down, at_term;
    logic [6:0]    next_count;
    logic [6:0]    units_v, tens_v;

    assign start_e = start & ~start_q;
    assign stop_e  = stop & ~stop_q;
    assign clear_e = clear & ~clear_q;

    // Terminal is 0 when counting down, MAX_COUNT when counting up; both roll over to the opposite end.
    always_comb begin
        down = 1'b0;
`ifdef COUNTER_CTRL_DOWN_EN
        down = dir;
`endif
        at_term    = down ? (count == 7'd0) : (count == MAXV);
        next_count = count + 7'd1;
        if (at_term)
            next_count = down ? MAXV : 7'd0;
        else if (down)
            next_count = count - 7'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            presc   <= '0;
            count   <= 7'd0;
            tick    <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clear_q <= 1'b1;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            clear_q <= clear;
            tick    <= 1'b0;
            if (WRAP)
                done <= 1'b0;
            if (clear_e) begin
                state   <= ST_IDLE;
                presc   <= '0;
                count   <= 7'd0;
                done    <= 1'b0;
                running <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start_e && !stop_e) begin
                        state   <= ST_RUN;
                        presc   <= '0;
                        running <= 1'b1;
                    end
                    // Prescaler is deliberately kept so a resume finishes the interrupted period.
                    ST_PAUSE: if (start_e && !stop_e) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                    ST_DONE: if (start_e && !stop_e) begin
                        state   <= ST_RUN;
                        presc   <= '0;
                        count   <= 7'd0;
                        done    <= 1'b0;
                        running <= 1'b1;
                    end
                    ST_RUN: begin
                        if (stop_e) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (presc == LAST) begin
                            presc <= '0;
                            tick  <= 1'b1;
                            if (at_term && !WRAP) begin
                                state   <= ST_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                count <= next_count;
                                done  <= at_term;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [6:0] d);
        case (d)
            7'd0:    return 7'b0000001;
            7'd1:    return 7'b1001111;
            7'd2:    return 7'b0010010;
            7'd3:    return 7'b0000110;
            7'd4:    return 7'b1001100;
            7'd5:    return 7'b0100100;
            7'd6:    return 7'b0100000;
            7'd7:    return 7'b0001111;
            7'd8:    return 7'b0000000;
            7'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Leading zero on the tens digit is blanked rather than shown.
    always_comb begin
        units_v = count % 7'd10;
        tens_v  = count / 7'd10;
        result  = {(tens_v == 7'd0) ? 7'b1111111 : seg7(tens_v), seg7(units_v)};
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: two instances (wrapping MAX 3, holding MAX 12) share stimulus and are
// compared every cycle against an arithmetic model of the run/pause/done behaviour.
module tb_counter_ctrl;

    localparam int DIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst, start, stop, clear, dir;
    logic [6:0]  dCount   [2];
    logic [13:0] dResult  [2];
    logic        dRunning [2];
    logic        dTick    [2];
    logic        dDone    [2];

    int nChecks = 0;
    int nFails  = 0;

    int maxc [2] = '{3, 12};
    bit wrapc[2] = '{1'b1, 1'b0};
    int mState[2], mCount[2], mPhase[2];
    bit mTick[2], mDone[2];
    bit prevStart, prevStop, prevClear;
    logic [6:0] segTab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always #5 clk = ~clk;

    counter_ctrl #(.DIV(DIV), .MAX_COUNT(3), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
`ifdef COUNTER_CTRL_DOWN_EN
        .dir(dir),
`endif
        .count(dCount[0]), .result(dResult[0]), .running(dRunning[0]), .tick(dTick[0]), .done(dDone[0])
    );

    counter_ctrl #(.DIV(DIV), .MAX_COUNT(12), .WRAP(1'b0)) u_hold (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
`ifdef COUNTER_CTRL_DOWN_EN
        .dir(dir),
`endif
        .count(dCount[1]), .result(dResult[1]), .running(dRunning[1]), .tick(dTick[1]), .done(dDone[1])
    );

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mState[i] = M_IDLE; mCount[i] = 0; mPhase[i] = 0; mTick[i] = 0; mDone[i] = 0;
        end
        prevStart = 1; prevStop = 1; prevClear = 1;
    endtask

    // One clock edge of the reference: edges, priority clear>stop>start, tick every DIV run cycles.
    task automatic modelStep();
        bit es, ep, ec, d, term;
        es = start && !prevStart; ep = stop && !prevStop; ec = clear && !prevClear;
        prevStart = start; prevStop = stop; prevClear = clear;
        d = 1'b0;
`ifdef COUNTER_CTRL_DOWN_EN
        d = dir;
`endif
        for (int i = 0; i < 2; i++) begin
            mTick[i] = 0;
            if (wrapc[i]) mDone[i] = 0;
            if (ec) begin
                mState[i] = M_IDLE; mCount[i] = 0; mPhase[i] = 0; mDone[i] = 0;
            end else if (mState[i] == M_RUN) begin
                if (ep) mState[i] = M_PAUSE;
                else begin
                    mPhase[i] = (mPhase[i] + 1) % DIV;
                    if (mPhase[i] == 0) begin
                        mTick[i] = 1;
                        term = d ? (mCount[i] == 0) : (mCount[i] == maxc[i]);
                        if (term && !wrapc[i]) begin
                            mState[i] = M_DONE; mDone[i] = 1;
                        end else begin
                            mCount[i] = d ? (mCount[i] + maxc[i]) % (maxc[i] + 1)
                                          : (mCount[i] + 1) % (maxc[i] + 1);
                            mDone[i] = term;
                        end
                    end
                end
            end else if (es && !ep) begin
                if (mState[i] != M_PAUSE) mPhase[i] = 0;
                if (mState[i] == M_DONE) begin mCount[i] = 0; mDone[i] = 0; end
                mState[i] = M_RUN;
            end
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        if (rst) modelStep();
        #1;
    endtask

    function automatic logic [23:0] obsv(int i);
        return {dCount[i], dResult[i], dRunning[i], dTick[i], dDone[i]};
    endfunction

    function automatic logic [23:0] expv(int i);
        int c = mCount[i];
        logic [6:0] tensSeg;
        tensSeg = (c / 10 == 0) ? 7'b1111111 : segTab[c / 10];
        return {7'(c), tensSeg, segTab[c % 10], mState[i] == M_RUN, mTick[i], mDone[i]};
    endfunction

    task automatic applyStimulus(input bit s, input bit p, input bit c);
        start = s; stop = p; clear = c;
    endtask

    task automatic test_reset();
        rst = 1'b0; dir = 1'b0;
        applyStimulus(0, 0, 0);
        modelReset();
        #2;
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (obsv(i) !== {7'd0, 14'b1111111_0000001, 3'b000}) begin
                nFails++;
                $display("[TB] FAIL reset_state inst%0d: got %b required %b", i, obsv(i),
                         {7'd0, 14'b1111111_0000001, 3'b000});
            end
        end
        #10 rst = 1'b1;
        repeat (3) begin
            stepClk();
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (obsv(i) !== expv(i)) begin
                    nFails++;
                    $display("[TB] FAIL reset_idle inst%0d: got %b required %b", i, obsv(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_count();
        logic [6:0] units [4] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b0000001};
        applyStimulus(1, 0, 0); stepClk(); applyStimulus(0, 0, 0);
        nChecks++;
        if (dRunning[0] !== 1'b1) begin
            nFails++; $display("[TB] FAIL count_running: got %b required 1", dRunning[0]);
        end
        for (int k = 1; k <= 17; k++) begin
            stepClk();
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (obsv(i) !== expv(i)) begin
                    nFails++;
                    $display("[TB] FAIL count_cycle%0d inst%0d: got %b required %b", k, i, obsv(i), expv(i));
                end
            end
            if (k % 4 == 0) begin
                nChecks++;
                if (dResult[0] !== {7'b1111111, units[k/4 - 1]} || dTick[0] !== 1'b1 ||
                    dDone[0] !== (k == 16)) begin
                    nFails++;
                    $display("[TB] FAIL count_tick%0d: got result %b tick %b done %b", k, dResult[0],
                             dTick[0], dDone[0]);
                end
            end
        end
        nChecks++;
        if (dDone[0] !== 1'b0) begin
            nFails++; $display("[TB] FAIL done_pulse_width: got %b required 0", dDone[0]);
        end
    endtask

    task automatic test_pause();
        applyStimulus(0, 0, 1); stepClk();
        applyStimulus(1, 0, 0); stepClk();
        applyStimulus(0, 0, 0);
        repeat (2) stepClk();
        applyStimulus(0, 1, 0); stepClk();
        applyStimulus(0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            stepClk();
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (obsv(i) !== expv(i)) begin
                    nFails++;
                    $display("[TB] FAIL pause_hold%0d inst%0d: got %b required %b", k, i, obsv(i), expv(i));
                end
            end
        end
        applyStimulus(1, 0, 0); stepClk();
        applyStimulus(0, 0, 0); stepClk(); stepClk();
        nChecks++;
        if (dTick[0] !== 1'b1 || dCount[0] !== 7'd1) begin
            nFails++;
            $display("[TB] FAIL pause_resume: got tick %b count %0d required tick 1 count 1", dTick[0], dCount[0]);
        end
    endtask

    task automatic test_clear_stop();
        repeat (5) stepClk();
        applyStimulus(0, 1, 1); stepClk();
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (obsv(i) !== {7'd0, 14'b1111111_0000001, 3'b000} || obsv(i) !== expv(i)) begin
                nFails++;
                $display("[TB] FAIL clear_stop inst%0d: got %b required %b", i, obsv(i), expv(i));
            end
        end
    endtask

    task automatic test_reset_midrun();
        applyStimulus(1, 0, 0); stepClk();
        applyStimulus(0, 0, 0);
        repeat (6) stepClk();
        #2 rst = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (obsv(i) !== {7'd0, 14'b1111111_0000001, 3'b000}) begin
                nFails++;
                $display("[TB] FAIL async_reset inst%0d: got %b required %b", i, obsv(i),
                         {7'd0, 14'b1111111_0000001, 3'b000});
            end
        end
        #2 rst = 1'b1;
    endtask

    task automatic test_wrap0();
        applyStimulus(0, 0, 1); stepClk();
        applyStimulus(1, 0, 0); stepClk();
        applyStimulus(0, 0, 0);
        for (int k = 0; k < 64; k++) begin
            stepClk();
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (obsv(i) !== expv(i)) begin
                    nFails++;
                    $display("[TB] FAIL hold_cycle%0d inst%0d: got %b required %b", k, i, obsv(i), expv(i));
                end
            end
        end
        nChecks++;
        if (dResult[1] !== 14'b1001111_0010010 || dDone[1] !== 1'b1 || dRunning[1] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL hold_terminal: got result %b done %b running %b", dResult[1], dDone[1], dRunning[1]);
        end
        applyStimulus(1, 0, 0); stepClk();
        applyStimulus(0, 0, 0);
        nChecks++;
        if (dCount[1] !== 7'd0 || dRunning[1] !== 1'b1 || dDone[1] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL hold_restart: got count %0d running %b done %b", dCount[1], dRunning[1], dDone[1]);
        end
    endtask

    task automatic test_held_start();
        applyStimulus(1, 0, 0);
        #2 rst = 1'b0;
        modelReset();
        #4 rst = 1'b1;
        repeat (5) stepClk();
        nChecks++;
        if (dRunning[0] !== 1'b0 || dRunning[1] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL held_start: got running %b %b required 0 0", dRunning[0], dRunning[1]);
        end
        applyStimulus(0, 0, 0); stepClk();
        applyStimulus(1, 0, 0); stepClk();
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (obsv(i) !== expv(i) || dRunning[i] !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL repress_start inst%0d: got %b required %b", i, obsv(i), expv(i));
            end
        end
    endtask

`ifdef COUNTER_CTRL_DOWN_EN
    task automatic test_down();
        dir = 1'b1;
        applyStimulus(0, 0, 1); stepClk();
        applyStimulus(1, 0, 0); stepClk();
        applyStimulus(0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            stepClk();
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (obsv(i) !== expv(i)) begin
                    nFails++;
                    $display("[TB] FAIL down_cycle%0d inst%0d: got %b required %b", k, i, obsv(i), expv(i));
                end
            end
            if (k % 4 == 0) begin
                nChecks++;
                if (dCount[0] !== 7'(4 - k / 4) || dDone[0] !== (k == 4)) begin
                    nFails++;
                    $display("[TB] FAIL down_tick%0d: got count %0d done %b", k, dCount[0], dDone[0]);
                end
            end
        end
        dir = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 40) == 0);
`ifdef COUNTER_CTRL_DOWN_EN
            dir = $urandom_range(0, 3) == 0;
`endif
            stepClk();
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (obsv(i) !== expv(i)) begin
                    nFails++;
                    $display("[TB] FAIL random%0d inst%0d: got %b required %b", k, i, obsv(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_pause();
        test_clear_stop();
        test_reset_midrun();
        test_wrap0();
        test_held_start();
`ifdef COUNTER_CTRL_DOWN_EN
        test_down();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
